// File: rtl/flasher_pkg.sv
// Shared definitions for the multi-channel LED flasher: channel mode encoding.
package flasher_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   // Only BLINK and BREATHE advance the per-channel rate counter.
   function automatic logic is_rate_mode(input mode_t mode);
      return (mode == MODE_BLINK) || (mode == MODE_BREATHE);
   endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: config load, rate counter, blink bit, breathe level/direction, PWM compare.
module led_channel
   import flasher_pkg::*;
#(
   parameter int RATE_BITS = 8,
   parameter int PWM_BITS  = 8
) (
   input  logic                 refclk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [1:0]           cfg_mode,
   input  logic [RATE_BITS-1:0] cfg_period,
   input  logic                 tick,
   input  logic [PWM_BITS-1:0]  pwm_cnt,
   output logic                 led
);

   localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

   mode_t                mode;
   logic [RATE_BITS-1:0] period;
   logic [RATE_BITS-1:0] rate_cnt;
   logic [RATE_BITS-1:0] last_cnt;
   logic                 blink_bit;
   logic [PWM_BITS-1:0]  level;
   logic                 dir_down;
   logic                 step;

   // A programmed period of 0 behaves exactly like 1.
   assign last_cnt = (period == '0) ? '0 : period - RATE_BITS'(1);
   assign step     = tick && is_rate_mode(mode) && (rate_cnt == last_cnt);

   // NOTE: state registers use non-blocking assignments so every channel samples
   // the same pre-edge values of tick and pwm_cnt; blocking here would create ordering races.
   always_ff @(posedge refclk) begin
      if (reset) begin
         mode      <= MODE_OFF;
         period    <= '0;
         rate_cnt  <= '0;
         blink_bit <= 1'b0;
         level     <= '0;
         dir_down  <= 1'b0;
      end else if (load) begin
         // A config write wins over a tick landing on the same edge.
         mode      <= mode_t'(cfg_mode);
         period    <= cfg_period;
         rate_cnt  <= '0;
         blink_bit <= 1'b0;
         level     <= '0;
         dir_down  <= 1'b0;
      end else if (tick && is_rate_mode(mode)) begin
         if (rate_cnt == last_cnt) begin
            rate_cnt <= '0;
         end else begin
            rate_cnt <= rate_cnt + RATE_BITS'(1);
         end

         if (step && (mode == MODE_BLINK)) begin
            blink_bit <= ~blink_bit;
         end

         // Triangle fade: turn around at either end instead of wrapping.
         if (step && (mode == MODE_BREATHE)) begin
            if (!dir_down) begin
               if (level == LEVEL_MAX) begin
                  dir_down <= 1'b1;
                  level    <= level - PWM_BITS'(1);
               end else begin
                  level    <= level + PWM_BITS'(1);
               end
            end else begin
               if (level == '0) begin
                  dir_down <= 1'b0;
                  level    <= level + PWM_BITS'(1);
               end else begin
                  level    <= level - PWM_BITS'(1);
               end
            end
         end
      end
   end

   // NOTE: led gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      led = 1'b0;
      case (mode)
         MODE_ON:      led = 1'b1;
         MODE_BLINK:   led = blink_bit;
         MODE_BREATHE: led = (level > pwm_cnt);
         default:      led = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_led_flasher.sv
// Multi-channel LED flasher top: shared tick prescaler, PWM counter, config decode and LED output register.
module multi_led_flasher
   import flasher_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 12_000_000,
   parameter int TICK_FREQUENCY  = 1_000,
   parameter int NUM_CH          = 4,
   parameter int RATE_BITS       = 8,
   parameter int PWM_BITS        = 8,
   localparam int CH_BITS        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 refclk,
   input  logic                 reset,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CH_BITS-1:0]   cfg_ch,
   input  logic [1:0]           cfg_mode,
   input  logic [RATE_BITS-1:0] cfg_period,
   output logic                 o_tick,
   output logic [NUM_CH-1:0]    o_led
);

   localparam int DIV        = CLOCK_FREQUENCY / TICK_FREQUENCY;
   localparam int PRESC_BITS = (DIV > 1) ? $clog2(DIV) : 1;

   if (DIV < 2) begin : g_div_check
      $error("multi_led_flasher: CLOCK_FREQUENCY/TICK_FREQUENCY must be at least 2");
   end
   if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_num_ch_check
      $error("multi_led_flasher: NUM_CH must be in 1..16");
   end

   logic [PRESC_BITS-1:0] presc_cnt;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic [NUM_CH-1:0]     led_next;
   logic                  accept;

   assign accept = cfg_valid && cfg_ready;

   always_ff @(posedge refclk) begin
      if (reset) begin
         presc_cnt <= '0;
         o_tick    <= 1'b0;
      end else if (presc_cnt == PRESC_BITS'(DIV - 1)) begin
         presc_cnt <= '0;
         o_tick    <= 1'b1;
      end else begin
         presc_cnt <= presc_cnt + PRESC_BITS'(1);
         o_tick    <= 1'b0;
      end
   end

   // The PWM frame wraps naturally at 2^PWM_BITS.
   always_ff @(posedge refclk) begin
      if (reset) begin
         pwm_cnt   <= '0;
         cfg_ready <= 1'b0;
         o_led     <= '0;
      end else begin
         pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
         cfg_ready <= 1'b1;
         o_led     <= led_next;
      end
   end

   // Out-of-range channel numbers match no channel and are dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic load;
      assign load = accept && (cfg_ch == CH_BITS'(i));

      led_channel #(
         .RATE_BITS (RATE_BITS),
         .PWM_BITS  (PWM_BITS)
      ) u_channel (
         .refclk     (refclk),
         .reset      (reset),
         .load       (load),
         .cfg_mode   (cfg_mode),
         .cfg_period (cfg_period),
         .tick       (o_tick),
         .pwm_cnt    (pwm_cnt),
         .led        (led_next[i])
      );
   end

endmodule

// File: tb/tb_multi_led_flasher.sv
// Self-checking bench for multi_led_flasher: directed tables/sequences plus random traffic against a tick-count model.
module tb_multi_led_flasher;
   import flasher_pkg::*;

   localparam int DIV       = 10;
   localparam int NUM_CH    = 4;
   localparam int RATE_BITS = 8;
   localparam int PWM_BITS  = 4;
   localparam int FRAME     = 1 << PWM_BITS;
   localparam int LEVEL_MAX = FRAME - 1;

   logic                 refclk = 1'b0;
   logic                 reset = 1'b1;
   logic                 cfg_valid = 1'b0;
   logic [1:0]           cfg_ch = '0;
   logic [1:0]           cfg_mode = '0;
   logic [RATE_BITS-1:0] cfg_period = '0;
   logic                 cfg_ready, o_tick;
   logic [NUM_CH-1:0]    o_led;
   logic                 cfg_ready3, o_tick3;
   logic [2:0]           o_led3;

   int checks = 0;
   int failures = 0;

   multi_led_flasher #(
      .CLOCK_FREQUENCY (1000), .TICK_FREQUENCY (100), .NUM_CH (NUM_CH),
      .RATE_BITS (RATE_BITS), .PWM_BITS (PWM_BITS)
   ) u_dut (
      .refclk (refclk), .reset (reset), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
      .cfg_ch (cfg_ch), .cfg_mode (cfg_mode), .cfg_period (cfg_period),
      .o_tick (o_tick), .o_led (o_led)
   );

   // Three-channel copy: channel number 3 is out of range here and must be dropped.
   multi_led_flasher #(
      .CLOCK_FREQUENCY (1000), .TICK_FREQUENCY (100), .NUM_CH (3),
      .RATE_BITS (RATE_BITS), .PWM_BITS (PWM_BITS)
   ) u_dut3 (
      .refclk (refclk), .reset (reset), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready3),
      .cfg_ch (cfg_ch), .cfg_mode (cfg_mode), .cfg_period (cfg_period),
      .o_tick (o_tick3), .o_led (o_led3)
   );

   always #5 refclk = ~refclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: brightness from ticks elapsed since config ----------------
   function automatic int tri_level(input int steps);
      int ph;
      ph = steps % (2 * LEVEL_MAX);
      return (ph <= LEVEL_MAX) ? ph : 2 * LEVEL_MAX - ph;
   endfunction

   function automatic bit ref_led(input int mode, input int period, input int ticks, input int pwm);
      int p, s;
      p = (period == 0) ? 1 : period;
      s = ticks / p;
      case (mode)
         1:       return 1'b1;
         2:       return (s % 2) == 1;
         3:       return tri_level(s) > pwm;
         default: return 1'b0;
      endcase
   endfunction

   bit              model_on = 1'b0;
   bit              model_stop = 1'b0;
   int              m_presc, m_pwm;
   bit              m_tick, m_ready;
   bit [NUM_CH-1:0] m_led;
   int              m_mode [NUM_CH];
   int              m_period [NUM_CH];
   int              m_ticks [NUM_CH];

   always @(posedge refclk) begin
      if (reset) begin
         model_on <= 1'b1;
         m_presc  <= 0;
         m_pwm    <= 0;
         m_tick   <= 1'b0;
         m_ready  <= 1'b0;
         m_led    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i]   <= 0;
            m_period[i] <= 0;
            m_ticks[i]  <= 0;
         end
      end else if (model_on) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_led[i] <= ref_led(m_mode[i], m_period[i], m_ticks[i], m_pwm);
            if (cfg_valid && m_ready && (int'(cfg_ch) == i)) begin
               m_mode[i]   <= int'(cfg_mode);
               m_period[i] <= int'(cfg_period);
               m_ticks[i]  <= 0;
            end else if (m_tick && (m_mode[i] >= 2)) begin
               m_ticks[i] <= m_ticks[i] + 1;
            end
         end
         m_tick  <= (m_presc == DIV - 1);
         m_presc <= (m_presc + 1) % DIV;
         m_pwm   <= (m_pwm + 1) % FRAME;
         m_ready <= 1'b1;
      end
   end

   always @(negedge refclk) begin
      if (model_on && !model_stop) begin
         check("model_led", 32'(o_led), 32'(m_led));
         check("model_tick", 32'(o_tick), 32'(m_tick));
         check("model_ready", 32'(cfg_ready), 32'(m_ready));
      end
   end

   // ---------------- stimulus helpers (all called at a falling edge) ----------------
   task automatic write_cfg(input int ch, input int mode, input int period);
      cfg_valid  = 1'b1;
      cfg_ch     = 2'(ch);
      cfg_mode   = 2'(mode);
      cfg_period = RATE_BITS'(period);
      @(negedge refclk);
      cfg_valid  = 1'b0;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge refclk);
         n++;
      end while (!o_tick && n < 4 * DIV);
   endtask

   task automatic measure_toggle(input int ch, output int clks);
      logic v;
      v = o_led[ch];
      clks = 0;
      do begin
         @(negedge refclk);
         clks++;
      end while (o_led[ch] == v && clks < 400);
   endtask

   task automatic sample_frame(input int ch, output int hi, inout int seen);
      hi = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (o_led[ch]) hi++;
         if (o_tick) seen++;
         @(negedge refclk);
      end
   endtask

   typedef struct {
      int              ch;
      int              mode;
      int              period;
      logic [NUM_CH-1:0] led;
   } vec_t;

   vec_t vecs [6];
   int   n, k, hi, seen, guard;
   logic [NUM_CH-1:0] prev_led;

   initial begin
      vecs[0] = '{ch: 0, mode: 1, period: 0, led: 4'b0001};
      vecs[1] = '{ch: 2, mode: 1, period: 0, led: 4'b0101};
      vecs[2] = '{ch: 0, mode: 0, period: 0, led: 4'b0100};
      vecs[3] = '{ch: 3, mode: 1, period: 7, led: 4'b1100};
      vecs[4] = '{ch: 2, mode: 0, period: 0, led: 4'b1000};
      vecs[5] = '{ch: 3, mode: 0, period: 0, led: 4'b0000};

      // Reset held three clocks, then release.
      reset = 1'b1;
      repeat (3) @(negedge refclk);
      check("reset_led", 32'(o_led), 0);
      check("reset_tick", 32'(o_tick), 0);
      check("reset_ready", 32'(cfg_ready), 0);
      reset = 1'b0;
      @(negedge refclk);
      check("ready_after_release", 32'(cfg_ready), 1);
      wait_tick(n);
      check("first_tick_delay", n + 1, DIV);
      wait_tick(n);
      check("tick_spacing", n, DIV);
      wait_tick(n);
      check("tick_spacing2", n, DIV);

      // ON/OFF table: output lags the accepting edge by one clock.
      prev_led = '0;
      for (int i = 0; i < 6; i++) begin
         write_cfg(vecs[i].ch, vecs[i].mode, vecs[i].period);
         check("onoff_lag", 32'(o_led), 32'(prev_led));
         @(negedge refclk);
         check("onoff_led", 32'(o_led), 32'(vecs[i].led));
         prev_led = vecs[i].led;
      end

      // BLINK period 3: first lit after three ticks, then a 30-clock half period.
      write_cfg(1, MODE_BLINK, 3);
      n = 0;
      k = 0;
      while (!o_led[1] && k < 100) begin
         if (o_tick) n++;
         @(negedge refclk);
         k++;
      end
      check("blink_first_ticks", n, 3);
      measure_toggle(1, n);
      check("blink_half_period", n, 3 * DIV);
      measure_toggle(1, n);
      check("blink_half_period2", n, 3 * DIV);
      check("blink_lit_before_reconfig", 32'(o_led[1]), 1);

      // Reconfigure while lit: restarts dark; period 0 toggles every tick.
      write_cfg(1, MODE_BLINK, 0);
      @(negedge refclk);
      check("reblink_dark", 32'(o_led[1]), 0);
      measure_toggle(1, n);
      measure_toggle(1, n);
      check("blink_p0_period", n, DIV);
      measure_toggle(1, n);
      check("blink_p0_period2", n, DIV);
      write_cfg(1, MODE_OFF, 0);

      // Config accepted on the same edge as a tick: that tick is ignored.
      k = 0;
      while (!o_tick && k < 50) begin
         @(negedge refclk);
         k++;
      end
      write_cfg(1, MODE_BLINK, 2);
      repeat (2 * DIV) @(negedge refclk);
      check("collide_still_dark", 32'(o_led[1]), 0);
      @(negedge refclk);
      check("collide_lit", 32'(o_led[1]), 1);
      write_cfg(1, MODE_OFF, 0);

      // Out-of-range channel on the three-channel instance is dropped.
      write_cfg(0, MODE_ON, 0);
      write_cfg(3, MODE_ON, 0);
      @(negedge refclk);
      check("drop_dut3", 32'(o_led3), 32'(3'b001));
      check("ch3_dut4", 32'(o_led), 32'(4'b1001));
      write_cfg(0, MODE_OFF, 0);
      write_cfg(3, MODE_OFF, 0);

      // BREATHE period 8: level constant for 80 clocks, so any full frame has level high clocks.
      write_cfg(2, MODE_BREATHE, 8);
      seen = 0;
      if (o_tick) seen++;
      @(negedge refclk);
      sample_frame(2, hi, seen);
      check("breathe_level0", hi, 0);
      for (int s = 1; s <= 17; s++) begin
         guard = 0;
         while (seen < 8 * s && guard < 200) begin
            if (o_tick) seen++;
            @(negedge refclk);
            guard++;
         end
         if (o_tick) seen++;
         @(negedge refclk);
         sample_frame(2, hi, seen);
         check("breathe_level", hi, tri_level(s));
      end

      // Reset during breathe with a pending write: write not applied.
      reset     = 1'b1;
      cfg_valid = 1'b1;
      cfg_ch    = 2'd0;
      cfg_mode  = MODE_ON;
      @(negedge refclk);
      check("midreset_led", 32'(o_led), 0);
      check("midreset_ready", 32'(cfg_ready), 0);
      check("midreset_tick", 32'(o_tick), 0);
      reset = 1'b0;
      @(negedge refclk);
      cfg_valid = 1'b0;
      repeat (3) @(negedge refclk);
      check("midreset_no_apply", 32'(o_led), 0);

      // Random traffic checked cycle by cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 7) == 0) begin
            cfg_valid  = 1'b1;
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = RATE_BITS'($urandom_range(0, 4));
         end else begin
            cfg_valid = 1'b0;
         end
         @(negedge refclk);
      end
      reset     = 1'b0;
      cfg_valid = 1'b0;
      @(negedge refclk);
      model_stop = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
